// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with default master, locked transfers and a hold limit
//   clk        clock
//   rst        synchronous, active-high reset
//   HBusReq    per-master bus request
//   HLock      per-master lock request
//   HTrans     HTrans of the current address-phase owner
//   HReady     slave HReady; every register advances only when it is high
//   HGrant     one-hot grant (registered)
//   HMaster    index of the current address-phase owner (registered, one transfer behind HGrant)
//   HMastLock  current address phase is locked (registered)
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int MASTER_BITS    = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] HBusReq,
    input  logic [NUM_MASTERS-1:0] HLock,
    input  logic [1:0]             HTrans,
    input  logic                   HReady,
    output logic [NUM_MASTERS-1:0] HGrant,
    output logic [MASTER_BITS-1:0] HMaster,
    output logic                   HMastLock
);
    typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} state_t;

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             HOLD_MAX  = 8'(MAX_HOLD);

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [MASTER_BITS-1:0] owner, pick;
    logic [7:0]             hold_cnt;
    logic                   any_req, others_req, own_req, own_lock;

    // Scans owner+1 upward with wrap; descending loop lets the nearest requester overwrite
    // farther ones, and the owner itself (offset NUM_MASTERS) is considered last.
    function automatic logic [MASTER_BITS-1:0] rr_pick(
        input logic [MASTER_BITS-1:0] cur,
        input logic [NUM_MASTERS-1:0] req
    );
        rr_pick = cur;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            int idx;
            idx = (int'(cur) + k) % NUM_MASTERS;
            if (req[idx]) rr_pick = MASTER_BITS'(idx);
        end
    endfunction

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (HGrant[i]) owner = MASTER_BITS'(i);
    end

    assign pick       = rr_pick(owner, HBusReq);
    assign any_req    = |HBusReq;
    assign others_req = |(HBusReq & ~HGrant);
    assign own_req    = HBusReq[owner];
    assign own_lock   = HLock[owner];

    // GRANTED and LOCKED share one rearbitration path; LOCKED behaves as if the hold
    // limit were already reached once the lock is released.
    always_comb begin
        state_nxt = state;
        grant_nxt = HGrant;
        case (state)
            IDLE: begin
                state_nxt = any_req ? GRANTED : IDLE;
                grant_nxt = any_req ? NUM_MASTERS'(1) << pick : DEF_GRANT;
            end
            default: begin
                if (own_req && own_lock) begin
                    state_nxt = LOCKED;
                end else if (!own_req) begin
                    state_nxt = any_req ? GRANTED : IDLE;
                    grant_nxt = any_req ? NUM_MASTERS'(1) << pick : DEF_GRANT;
                end else begin
                    state_nxt = GRANTED;
                    if ((hold_cnt == HOLD_MAX || state == LOCKED) && others_req)
                        grant_nxt = NUM_MASTERS'(1) << pick;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            HGrant    <= DEF_GRANT;
            HMaster   <= MASTER_BITS'(DEFAULT_MASTER);
            HMastLock <= 1'b0;
            hold_cnt  <= '0;
        end else if (HReady) begin
            state     <= state_nxt;
            HGrant    <= grant_nxt;
            HMaster   <= owner;
            HMastLock <= own_req & own_lock;
            hold_cnt  <= (grant_nxt != HGrant) ? 8'd0 :
                         (state != LOCKED && HTrans[1] && hold_cnt != HOLD_MAX) ? hold_cnt + 8'd1 :
                         hold_cnt;
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scoreboard bench for ahb_arbiter (2 masters, default 0, hold limit 4)
//   Stimulus pushes the expected {HGrant, HMaster, HMastLock} for the next edge into a
//   queue; a monitor on the falling edge pops and compares.
module tb_ahb_arbiter;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    typedef struct {
        int         cyc;
        logic [1:0] g;
        logic       m;
        logic       l;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] HBusReq, HLock, HTrans, HGrant;
    logic       HReady, HMaster, HMastLock;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    exp_t       q[$];

    ahb_arbiter #(
        .NUM_MASTERS(2),
        .MASTER_BITS(1),
        .DEFAULT_MASTER(0),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .HBusReq(HBusReq),
        .HLock(HLock),
        .HTrans(HTrans),
        .HReady(HReady),
        .HGrant(HGrant),
        .HMaster(HMaster),
        .HMastLock(HMastLock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (HGrant === e.g && HMaster === e.m && HMastLock === e.l)
                passed++;
            else
                $display("FAIL %s @cyc %0d: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                         e.name, cyc, HGrant, HMaster, HMastLock, e.g, e.m, e.l);
        end
    end

    task automatic step(input logic r, input logic rdy, input logic [1:0] req, input logic [1:0] lk,
                        input logic [1:0] tr, input logic [1:0] eg, input logic em, input logic el,
                        input string nm);
        rst = r;
        HReady = rdy;
        HBusReq = req;
        HLock = lk;
        HTrans = tr;
        q.push_back('{cyc + 1, eg, em, el, nm});
        @(posedge clk);
        #1;
    endtask

    logic [1:0] g3 [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                            2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    logic       m3 [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        step(1, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "reset");
        step(1, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "reset");
        for (int i = 0; i < 10; i++) step(0, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "idle_default");

        step(0, 1, 2'b10, 2'b00, NS, 2'b10, 0, 0, "m1_grant");
        step(0, 1, 2'b10, 2'b00, NS, 2'b10, 1, 0, "m1_hmaster");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 1, 0, "m1_release");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "back_default");

        for (int i = 0; i < 12; i++) step(0, 1, 2'b11, 2'b00, NS, g3[i], m3[i], 0, "rr_preempt");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 1, 0, "rr_release");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "rr_idle");

        step(0, 1, 2'b11, 2'b10, NS, 2'b10, 0, 0, "lock_grant");
        for (int i = 0; i < 10; i++) step(0, 1, 2'b11, 2'b10, NS, 2'b10, 1, 1, "lock_hold");
        step(0, 1, 2'b11, 2'b00, NS, 2'b01, 1, 0, "unlock_rearb");
        step(0, 1, 2'b11, 2'b00, NS, 2'b01, 0, 0, "unlock_hmaster");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "unlock_idle");

        for (int i = 0; i < 3; i++) step(0, 0, 2'b10, 2'b00, NS, 2'b01, 0, 0, "stall_frozen");
        step(0, 1, 2'b10, 2'b00, NS, 2'b10, 0, 0, "stall_resume");
        step(0, 1, 2'b10, 2'b00, NS, 2'b10, 1, 0, "stall_hmaster");
        step(0, 1, 2'b11, 2'b00, NS, 2'b10, 1, 0, "hold_cnt2");
        step(0, 1, 2'b11, 2'b00, NS, 2'b10, 1, 0, "hold_cnt3");
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b00, NS, 2'b10, 1, 0, "hold_frozen");
        step(0, 1, 2'b11, 2'b00, NS, 2'b10, 1, 0, "hold_cnt4");
        step(0, 1, 2'b11, 2'b00, NS, 2'b01, 1, 0, "hold_preempt");
        step(0, 1, 2'b11, 2'b00, NS, 2'b01, 0, 0, "hold_hmaster");

        step(0, 1, 2'b10, 2'b10, NS, 2'b10, 0, 0, "lock2_grant");
        step(0, 1, 2'b10, 2'b10, NS, 2'b10, 1, 1, "lock2_enter");
        step(0, 1, 2'b10, 2'b10, NS, 2'b10, 1, 1, "lock2_hold");
        step(1, 0, 2'b10, 2'b10, NS, 2'b01, 0, 0, "rst_in_lock");
        step(0, 1, 2'b00, 2'b00, ID, 2'b01, 0, 0, "post_rst_idle");
        step(0, 1, 2'b11, 2'b00, NS, 2'b10, 0, 0, "post_rst_state_idle");

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total += q.size();
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
